// File: rtl/reg_7bit_pkg.sv
// Shared constants for the parallel-load data register.
package reg_7bit_pkg;

  localparam int unsigned REG_WIDTH_DEFAULT = 7;
  localparam logic [REG_WIDTH_DEFAULT-1:0] REG_RESET_VALUE_DEFAULT = '0;

endpackage

// File: rtl/reg_7bit_d_ff.sv
// Single-bit D flip-flop cell with asynchronous active-low clear to RESET_BIT.
module d_ff #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_7bit.sv
// Parallel-load register built from one d_ff cell per bit; no enable, loads every edge.
module reg_7bit
  import reg_7bit_pkg::*;
#(
  parameter int unsigned          WIDTH       = REG_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0]     RESET_VALUE = WIDTH'(REG_RESET_VALUE_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .d     (d[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_reg_7bit.sv
// Scoreboard bench for reg_7bit: default 7-bit instance and a 4-bit instance with nonzero reset value.
module tb_reg_7bit;

  localparam logic [6:0] RV7 = 7'b0000000;
  localparam logic [3:0] RV4 = 4'b1010;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  e7;
    logic [3:0]  e4;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [6:0] d7;
  logic [6:0] q7;
  logic [3:0] d4;
  logic [3:0] q4;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc;
  int          checks;
  int          errors;

  logic       prev_rst;
  logic [6:0] prev_d;

  reg_7bit u_dut7 (
    .clk   (clk),
    .reset (reset),
    .d     (d7),
    .q     (q7)
  );

  reg_7bit #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .d     (d4),
    .q     (q4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due in the current cycle, sampled at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (q7 !== e.e7) begin
        errors++;
        $display("FAIL q7 cyc=%0d got=%b want=%b", e.cyc, q7, e.e7);
      end
      checks++;
      if (q4 !== e.e4) begin
        errors++;
        $display("FAIL q4 cyc=%0d got=%b want=%b", e.cyc, q4, e.e4);
      end
    end
  end

  // Reference: a register is cleared whenever reset is low; otherwise it shows
  // whatever was presented at the previous edge, provided reset was high then.
  task automatic step(input logic rst, input logic [6:0] dv, input bit coincident);
    logic [6:0] x7;
    logic [3:0] x4;
    @(posedge clk);
    if (!coincident) #3;
    reset = rst;
    d7    = dv;
    d4    = dv[3:0];
    if (coincident) #3;
    if (!rst || !prev_rst) begin
      x7 = RV7;
      x4 = RV4;
    end else begin
      x7 = prev_d;
      x4 = prev_d[3:0];
    end
    sb.push_back('{cyc, x7, x4});
    prev_rst = rst;
    prev_d   = dv;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    d7       = 7'b1010101;
    d4       = 4'b0101;
    prev_rst = 1'b0;
    prev_d   = '0;

    repeat (3) step(1'b0, 7'b1010101, 1'b0);
    step(1'b1, 7'b0000001, 1'b0);
    step(1'b1, 7'b1111111, 1'b0);
    step(1'b1, 7'b0101010, 1'b0);
    step(1'b1, 7'b0000000, 1'b0);
    step(1'b1, 7'b1111111, 1'b0);
    step(1'b1, 7'b1111111, 1'b0);
    step(1'b0, 7'b0011001, 1'b0);
    step(1'b1, 7'b0011001, 1'b0);
    step(1'b1, 7'b1000000, 1'b0);
    step(1'b0, 7'b1000000, 1'b1);
    step(1'b1, 7'b0000110, 1'b0);
    step(1'b1, 7'b1100011, 1'b0);

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 7) != 0), 7'($urandom), 1'b0);
    end
    step(1'b1, 7'b0110011, 1'b0);
    step(1'b1, 7'b0110011, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
